// File: rtl/wave_monitor.sv
// Measures the sampled generator waveform one period at a time. A period runs from one rising
// threshold crossing to the next. Each complete period is reported with its shape class, length,
// minimum and maximum. The lock flag rises when two consecutive reports agree.
module wave_monitor #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned THRESH   = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_sample_en,
  input  logic [WIDTH-1:0]    i_wave,
  output logic                o_meas_valid,
  output logic [1:0]          o_shape,
  output logic [PERIOD_W-1:0] o_period,
  output logic [WIDTH-1:0]    o_wave_min,
  output logic [WIDTH-1:0]    o_wave_max,
  output logic                o_locked
);

  localparam logic [PERIOD_W-1:0] CntMax    = '1;
  localparam logic [WIDTH:0]      ThreshV   = THRESH[WIDTH:0];
  localparam logic [1:0]          ShSquare  = 2'd0;
  localparam logic [1:0]          ShSaw     = 2'd1;
  localparam logic [1:0]          ShTri     = 2'd2;
  localparam logic [1:0]          ShUnknown = 2'd3;

  typedef enum logic [1:0] {StIdle, StArm, StMeasure} state_e;

  state_e                r_state, w_state_d;
  logic [WIDTH-1:0]      r_prev, w_prev_d;
  logic [PERIOD_W-1:0]   r_cnt, w_cnt_d;
  logic [WIDTH-1:0]      r_min, w_min_d, r_max, w_max_d;
  logic [PERIOD_W-1:0]   r_up, w_up_d, r_down, w_down_d;
  logic [1:0]            r_jumps, w_jumps_d;
  logic                  r_meas_valid, w_meas_valid_d;
  logic [1:0]            r_shape, w_shape_d;
  logic [PERIOD_W-1:0]   r_period, w_period_d;
  logic [WIDTH-1:0]      r_wave_min, w_wave_min_d, r_wave_max, w_wave_max_d;
  logic                  r_locked, w_locked_d;
  logic [1:0]            r_last_shape, w_last_shape_d;
  logic [PERIOD_W-1:0]   r_last_period, w_last_period_d;

  logic signed [WIDTH:0] w_delta;
  logic                  w_is_up, w_is_down, w_is_jump, w_cross;
  logic [PERIOD_W-1:0]   w_up_inc, w_down_inc, w_cnt_inc;
  logic [1:0]            w_jumps_inc;
  logic [WIDTH-1:0]      w_min_upd, w_max_upd;
  logic                  w_report;
  logic [1:0]            w_rep_shape;
  logic [PERIOD_W-1:0]   w_rep_period;
  logic [WIDTH-1:0]      w_rep_min, w_rep_max;

  function automatic logic [1:0] classify(input logic [PERIOD_W-1:0] up,
                                          input logic [PERIOD_W-1:0] down,
                                          input logic [1:0]          jumps);
    if (up == '0 && down == '0 && jumps != 2'd0) return ShSquare;
    if (up != '0 && down == '0 && jumps == 2'd1) return ShSaw;
    if (up != '0 && down != '0 && jumps == 2'd0) return ShTri;
    return ShUnknown;
  endfunction

  // Per-sample step classification, crossing detect and saturating counter increments.
  always_comb begin
    w_delta     = $signed({1'b0, i_wave}) - $signed({1'b0, r_prev});
    w_is_up     = (w_delta == {{WIDTH{1'b0}}, 1'b1});
    w_is_down   = (w_delta == {(WIDTH + 1){1'b1}});
    w_is_jump   = !w_is_up && !w_is_down && (w_delta != '0);
    w_cross     = ({1'b0, r_prev} < ThreshV) && ({1'b0, i_wave} >= ThreshV);
    w_up_inc    = (w_is_up && r_up != CntMax) ? r_up + 1'b1 : r_up;
    w_down_inc  = (w_is_down && r_down != CntMax) ? r_down + 1'b1 : r_down;
    w_jumps_inc = (w_is_jump && r_jumps != 2'd3) ? r_jumps + 2'd1 : r_jumps;
    w_cnt_inc   = (r_cnt != CntMax) ? r_cnt + 1'b1 : r_cnt;
    w_min_upd   = (i_wave < r_min) ? i_wave : r_min;
    w_max_upd   = (i_wave > r_max) ? i_wave : r_max;
  end

  // FSM next state, period statistics and report generation.
  always_comb begin
    w_state_d       = r_state;
    w_prev_d        = r_prev;
    w_cnt_d         = r_cnt;
    w_min_d         = r_min;
    w_max_d         = r_max;
    w_up_d          = r_up;
    w_down_d        = r_down;
    w_jumps_d       = r_jumps;
    w_meas_valid_d  = 1'b0;
    w_shape_d       = r_shape;
    w_period_d      = r_period;
    w_wave_min_d    = r_wave_min;
    w_wave_max_d    = r_wave_max;
    w_locked_d      = r_locked;
    w_last_shape_d  = r_last_shape;
    w_last_period_d = r_last_period;
    w_report        = 1'b0;
    w_rep_shape     = ShUnknown;
    w_rep_period    = '0;
    w_rep_min       = '0;
    w_rep_max       = '0;

    if (i_sample_en) begin
      w_prev_d = i_wave;
      unique case (r_state)
        StIdle: w_state_d = StArm;
        StArm: begin
          if (w_cross) begin
            w_state_d = StMeasure;
            w_cnt_d   = {{(PERIOD_W - 1){1'b0}}, 1'b1};
            w_min_d   = i_wave;
            w_max_d   = i_wave;
            w_up_d    = '0;
            w_down_d  = '0;
            w_jumps_d = '0;
          end
        end
        StMeasure: begin
          if (w_cross) begin
            // Min/max exclude the ending sample; step counts include its transition.
            w_report     = 1'b1;
            w_rep_shape  = classify(w_up_inc, w_down_inc, w_jumps_inc);
            w_rep_period = r_cnt;
            w_rep_min    = r_min;
            w_rep_max    = r_max;
            w_cnt_d      = {{(PERIOD_W - 1){1'b0}}, 1'b1};
            w_min_d      = i_wave;
            w_max_d      = i_wave;
            w_up_d       = '0;
            w_down_d     = '0;
            w_jumps_d    = '0;
          end else begin
            w_cnt_d   = w_cnt_inc;
            w_min_d   = w_min_upd;
            w_max_d   = w_max_upd;
            w_up_d    = w_up_inc;
            w_down_d  = w_down_inc;
            w_jumps_d = w_jumps_inc;
            if (w_cnt_inc == CntMax) begin
              // No crossing within the counter range: give up and re-arm.
              w_report     = 1'b1;
              w_rep_shape  = ShUnknown;
              w_rep_period = CntMax;
              w_rep_min    = w_min_upd;
              w_rep_max    = w_max_upd;
              w_state_d    = StArm;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end

    if (w_report) begin
      w_meas_valid_d  = 1'b1;
      w_shape_d       = w_rep_shape;
      w_period_d      = w_rep_period;
      w_wave_min_d    = w_rep_min;
      w_wave_max_d    = w_rep_max;
      w_locked_d      = (w_rep_shape != ShUnknown) && (w_rep_shape == r_last_shape) &&
                        (w_rep_period == r_last_period);
      w_last_shape_d  = w_rep_shape;
      w_last_period_d = w_rep_period;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_prev        <= '0;
      r_cnt         <= '0;
      r_min         <= '0;
      r_max         <= '0;
      r_up          <= '0;
      r_down        <= '0;
      r_jumps       <= '0;
      r_meas_valid  <= 1'b0;
      r_shape       <= '0;
      r_period      <= '0;
      r_wave_min    <= '0;
      r_wave_max    <= '0;
      r_locked      <= 1'b0;
      r_last_shape  <= ShUnknown;
      r_last_period <= '0;
    end else begin
      r_state       <= w_state_d;
      r_prev        <= w_prev_d;
      r_cnt         <= w_cnt_d;
      r_min         <= w_min_d;
      r_max         <= w_max_d;
      r_up          <= w_up_d;
      r_down        <= w_down_d;
      r_jumps       <= w_jumps_d;
      r_meas_valid  <= w_meas_valid_d;
      r_shape       <= w_shape_d;
      r_period      <= w_period_d;
      r_wave_min    <= w_wave_min_d;
      r_wave_max    <= w_wave_max_d;
      r_locked      <= w_locked_d;
      r_last_shape  <= w_last_shape_d;
      r_last_period <= w_last_period_d;
    end
  end

  assign o_meas_valid = r_meas_valid;
  assign o_shape      = r_shape;
  assign o_period     = r_period;
  assign o_wave_min   = r_wave_min;
  assign o_wave_max   = r_wave_max;
  assign o_locked     = r_locked;

endmodule

// File: tb/tb_wave_monitor.sv
// Directed bench for wave_monitor: drives square, sawtooth, triangle and constant waveforms and
// checks each report against hand-computed values.
module tb_wave_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [4:0] wave;
  logic       meas_valid;
  logic [1:0] shape;
  logic [7:0] period;
  logic [4:0] wave_min;
  logic [4:0] wave_max;
  logic       locked;

  int n_total = 0;
  int n_bad   = 0;
  int gen_kind;
  int gen_phase;
  logic en_toggle;

  always #5 clk = ~clk;

  wave_monitor #(
    .WIDTH   (5),
    .PERIOD_W(8),
    .THRESH  (10)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sample_en (sample_en),
    .i_wave      (wave),
    .o_meas_valid(meas_valid),
    .o_shape     (shape),
    .o_period    (period),
    .o_wave_min  (wave_min),
    .o_wave_max  (wave_max),
    .o_locked    (locked)
  );

  // 0 square (10 low, 10 high), 1 sawtooth 0..20, 2 triangle 0..20..1, else constant 5.
  function automatic logic [4:0] gen(input int kind, input int p);
    int q;
    q = p % 40;
    case (kind)
      0:       return ((p % 20) < 10) ? 5'd0 : 5'd20;
      1:       return 5'(p % 21);
      2:       return (q <= 20) ? 5'(q) : 5'(40 - q);
      default: return 5'd5;
    endcase
  endfunction

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive the next sample (junk 15 while disabled), then settle past the edge.
  task automatic tick();
    wave = sample_en ? gen(gen_kind, gen_phase) : 5'd15;
    @(posedge clk);
    #1;
    if (sample_en) gen_phase++;
    if (en_toggle) sample_en = ~sample_en;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_valid"},  meas_valid, 0);
    check_eq({tag, "_shape"},  shape, 0);
    check_eq({tag, "_period"}, period, 0);
    check_eq({tag, "_min"},    wave_min, 0);
    check_eq({tag, "_max"},    wave_max, 0);
    check_eq({tag, "_locked"}, locked, 0);
  endtask

  task automatic expect_report(input string tag, input int budget, input int exp_shape,
                               input int exp_period, input int exp_min, input int exp_max,
                               input int exp_locked, output int gap);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!meas_valid && gap < budget);
    check_eq({tag, "_valid"},  meas_valid, 1);
    check_eq({tag, "_shape"},  shape, exp_shape);
    check_eq({tag, "_period"}, period, exp_period);
    check_eq({tag, "_min"},    wave_min, exp_min);
    check_eq({tag, "_max"},    wave_max, exp_max);
    check_eq({tag, "_locked"}, locked, exp_locked);
  endtask

  initial begin
    int gap;
    rst       = 1'b0;
    sample_en = 1'b1;
    wave      = 5'd0;
    gen_kind  = 0;
    gen_phase = 0;
    en_toggle = 1'b0;

    do_reset();
    check_cleared("reset");

    // Square: crossing at 10, reports at samples 30, 50, 70.
    gen_phase = 0;
    expect_report("sq1", 60, 0, 20, 0, 20, 0, gap);
    check_eq("sq1_gap", gap, 31);
    expect_report("sq2", 40, 0, 20, 0, 20, 1, gap);
    check_eq("sq2_gap", gap, 20);
    expect_report("sq3", 40, 0, 20, 0, 20, 1, gap);
    tick();
    check_eq("hold_valid",  meas_valid, 0);
    check_eq("hold_period", period, 20);
    check_eq("hold_locked", locked, 1);

    // Sawtooth: crossing 9->10 at 10, reports at 31, 52, 73.
    do_reset();
    gen_kind  = 1;
    gen_phase = 0;
    expect_report("saw1", 60, 1, 21, 0, 20, 0, gap);
    expect_report("saw2", 40, 1, 21, 0, 20, 1, gap);
    expect_report("saw3", 40, 1, 21, 0, 20, 1, gap);

    // Switch to triangle mid-period: short mixed period, then clean 40-sample periods.
    gen_kind  = 2;
    gen_phase = 0;
    expect_report("mix", 40, 1, 11, 0, 10, 0, gap);
    expect_report("tri1", 60, 2, 40, 0, 20, 0, gap);
    expect_report("tri2", 60, 2, 40, 0, 20, 1, gap);

    // Constant 5 right after a crossing (sample value 10): times out after 255 samples.
    gen_kind = 3;
    expect_report("tmo", 300, 3, 255, 5, 10, 0, gap);
    check_eq("tmo_gap", gap, 254);

    // Back in ARM: first crossing is not reported, second is.
    gen_kind  = 0;
    gen_phase = 0;
    expect_report("rearm", 60, 0, 20, 0, 20, 0, gap);
    check_eq("rearm_gap", gap, 31);

    // Reset in the middle of a period.
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    check_cleared("mid_rst");
    rst = 1'b0;
    expect_report("after_rst", 60, 0, 20, 0, 20, 0, gap);
    check_eq("rst_gap", gap, 34);

    // Sawtooth with sample_en alternating: disabled cycles carry junk and must be ignored.
    do_reset();
    gen_kind  = 1;
    gen_phase = 0;
    sample_en = 1'b1;
    en_toggle = 1'b1;
    expect_report("tog1", 120, 1, 21, 0, 20, 0, gap);
    expect_report("tog2", 80, 1, 21, 0, 20, 1, gap);
    check_eq("tog2_gap", gap, 42);
    en_toggle = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
